// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: opcodes, arbiter states and flag helpers shared by alu_arbiter and its ALU
package alu_arb_pkg;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {IDLE, EXEC, FULL} state_t;

    function automatic logic is_slow(input logic [3:0] op);
        return op == OP_RED || op == OP_PADDSB;
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return op[3:2] == 2'b11;
    endfunction

    // Write-enable per flag bit, ordered {Z,V,N}
    function automatic logic [2:0] flag_mask(input logic [3:0] op);
        return (op == OP_ADD || op == OP_SUB) ? 3'b111 :
               (op inside {OP_XOR, OP_SLL, OP_SRA, OP_ROR, OP_RED, OP_PADDSB}) ? 3'b100 : 3'b000;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: combinational 16-bit execute-stage ALU
//   op  : 4-bit opcode
//   a,b : operands RS / RD
//   imm : 8-bit immediate (shift amount in imm[3:0], offset for LW/SW, byte for LLB/LHB)
//   res : result (0 for branch/halt opcodes)
//   ovfl: signed overflow of ADD/SUB
module alu_arbiter_alu
    import alu_arb_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [7:0]  imm,
    output logic [15:0] res,
    output logic        ovfl
);

    logic        sub;
    logic [15:0] bb, sum, padd, red, mem;
    logic [9:0]  red_s;
    logic [4:0]  ns;

    assign sub   = op == OP_SUB;
    assign bb    = sub ? ~b : b;
    assign sum   = a + bb + {15'd0, sub};
    assign ovfl  = (a[15] == bb[15]) && (sum[15] != a[15]);
    // Sum of the four signed bytes of A and B, sign-extended to 16 bits
    assign red_s = {{2{a[15]}}, a[15:8]} + {{2{a[7]}}, a[7:0]} + {{2{b[15]}}, b[15:8]} + {{2{b[7]}}, b[7:0]};
    assign red   = {{6{red_s[9]}}, red_s};
    assign mem   = (a & 16'hFFFE) + {{7{imm[7]}}, imm, 1'b0};

    // Four independent signed nibble adds, each saturating to [-8, 7]
    always_comb begin
        padd = '0;
        ns   = '0;
        for (int i = 0; i < 4; i++) begin
            ns = {a[4*i+3], a[4*i+:4]} + {b[4*i+3], b[4*i+:4]};
            padd[4*i+:4] = (ns[4] != ns[3]) ? (ns[4] ? 4'h8 : 4'h7) : ns[3:0];
        end
    end

    always_comb begin
        res = '0;
        case (op)
            OP_ADD, OP_SUB: res = sum;
            OP_XOR:         res = a ^ b;
            OP_RED:         res = red;
            OP_SLL:         res = a << imm[3:0];
            OP_SRA:         res = $signed(a) >>> imm[3:0];
            OP_ROR:         res = 16'({a, a} >> imm[3:0]);
            OP_PADDSB:      res = padd;
            OP_LW, OP_SW:   res = mem;
            OP_LLB:         res = {a[15:8], imm};
            OP_LHB:         res = {imm, a[7:0]};
            default:        res = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters with registered result and Z/V/N flags
//   req0_* / req1_* : valid/ready request ports (op, a, b, imm); port 0 main pipeline, port 1 sequencer
//   rsp_*           : registered result (valid/ready, src, res, err, post-update flags)
//   flags_q         : architectural {Z,V,N}
//   busy            : a slow op is executing or a result is pending
module alu_arbiter
    import alu_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic [7:0]  req0_imm,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic [7:0]  req1_imm,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_src,
    output logic [15:0] rsp_res,
    output logic        rsp_err,
    output logic [2:0]  rsp_flags,
    output logic [2:0]  flags_q,
    output logic        busy
);

    state_t      state_q, state_d;
    logic        last_q, last_d, src_q, src_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [7:0]  imm_q, imm_d;
    logic [15:0] rsp_res_q, rsp_res_d;
    logic        rsp_src_q, rsp_src_d, rsp_err_q, rsp_err_d;
    logic [2:0]  rsp_flags_q, rsp_flags_d, flags_d;

    logic        can_issue, sel, xfer, cap, exec, alu_ovfl;
    logic [3:0]  g_op, alu_op;
    logic [15:0] g_a, g_b, alu_a, alu_b, alu_res;
    logic [7:0]  g_imm, alu_imm;
    logic [2:0]  calc, mask, flags_new;

    assign exec       = state_q == EXEC;
    assign can_issue  = state_q == IDLE || (state_q == FULL && rsp_ready);
    // On a tie the port not granted last wins; otherwise whichever port is valid
    assign sel        = (req0_valid && req1_valid) ? !last_q : req1_valid;
    assign req0_ready = can_issue && req0_valid && !sel;
    assign req1_ready = can_issue && req1_valid && sel;
    assign xfer       = req0_ready || req1_ready;

    assign g_op  = sel ? req1_op  : req0_op;
    assign g_a   = sel ? req1_a   : req0_a;
    assign g_b   = sel ? req1_b   : req0_b;
    assign g_imm = sel ? req1_imm : req0_imm;

    // The ALU sees the latched operands while a slow op runs, the granted port otherwise
    assign alu_op  = exec ? op_q  : g_op;
    assign alu_a   = exec ? a_q   : g_a;
    assign alu_b   = exec ? b_q   : g_b;
    assign alu_imm = exec ? imm_q : g_imm;

    alu_arbiter_alu u_alu (
        .op  (alu_op),
        .a   (alu_a),
        .b   (alu_b),
        .imm (alu_imm),
        .res (alu_res),
        .ovfl(alu_ovfl)
    );

    assign cap       = exec || (xfer && !is_slow(g_op));
    assign calc      = {alu_res == '0, alu_ovfl, alu_res[15]};
    assign mask      = flag_mask(alu_op);
    assign flags_new = (calc & mask) | (flags_q & ~mask);

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        src_d       = src_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        imm_d       = imm_q;
        rsp_res_d   = rsp_res_q;
        rsp_src_d   = rsp_src_q;
        rsp_err_d   = rsp_err_q;
        rsp_flags_d = rsp_flags_q;
        flags_d     = flags_q;
        if (state_q == FULL && rsp_ready) state_d = IDLE;
        if (xfer) begin
            last_d  = sel;
            src_d   = sel;
            op_d    = g_op;
            a_d     = g_a;
            b_d     = g_b;
            imm_d   = g_imm;
            state_d = is_slow(g_op) ? EXEC : FULL;
        end
        if (exec) state_d = FULL;
        if (cap) begin
            rsp_res_d   = is_illegal(alu_op) ? 16'h0000 : alu_res;
            rsp_err_d   = is_illegal(alu_op);
            rsp_src_d   = exec ? src_q : sel;
            rsp_flags_d = flags_new;
            flags_d     = flags_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            src_q       <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            imm_q       <= '0;
            rsp_res_q   <= '0;
            rsp_src_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_flags_q <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            src_q       <= src_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            imm_q       <= imm_d;
            rsp_res_q   <= rsp_res_d;
            rsp_src_q   <= rsp_src_d;
            rsp_err_q   <= rsp_err_d;
            rsp_flags_q <= rsp_flags_d;
            flags_q     <= flags_d;
        end
    end

    assign rsp_valid = state_q == FULL;
    assign busy      = state_q != IDLE;
    assign rsp_res   = rsp_res_q;
    assign rsp_src   = rsp_src_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_flags = rsp_flags_q;

endmodule
